filter_reduce_accum_unit: RTL and testbench
===========================================

Name: filter_reduce_accum_unit

Overview:
- Next-generation filter/reduce stage in the trace-processing pipeline.
- Per chain, expands each input vector into an M x N matrix using threshold rows from a local vector register file (FUVRF), reduces along a selectable axis, and either emits the result per vector or accumulates it until end-of-frame.
- Sits between the upstream vector pipeline stage and the downstream vector compressor/buffer.
- Firmware is reconfigurable at runtime through the shared configId/configData bus.

Parameters:
- N, 8, vector lanes.
- M, 8, filter rows; M <= N is required when reducing along N.
- DATA_WIDTH, 32, lane width, two's complement.
- MAX_CHAINS, 4, independent chains; power of two, >= 2.
- PERSONAL_CONFIG_ID, 0, configId value addressing this unit.
- FUVRF_SIZE, 4, threshold-row entries; power of two.
- INITIAL_FIRMWARE_OP / _ADDR / _AXIS / _ACCUM, all-zero arrays [0:MAX_CHAINS-1] of 8 bits, reset firmware values.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- tracing  in  1  pipeline enable
- valid_in  in  1  input vector valid
- eof_in  in  1  last vector of frame
- chainId_in  in  clog2(MAX_CHAINS)  chain of input vector
- configId  in  8  config target id
- configData  in  8  config byte
- thr_we  in  1  FUVRF write enable
- thr_addr  in  clog2(FUVRF_SIZE)  FUVRF write address
- thr_data  in  M*DATA_WIDTH  threshold row; row m at bits [m*DW +: DW]
- vector_in  in  N x DATA_WIDTH  input vector
- vector_out  out  N x DATA_WIDTH  result vector
- chainId_out  out  clog2(MAX_CHAINS)  chain of result
- valid_out  out  1  result valid
- eof_out  out  1  result closes frame

Behaviour:
- Reset (rst_n=0 at posedge): vector_out all 0, chainId_out 0, valid_out 0, eof_out 0. Pipeline valids cleared. All accumulators 0. Firmware registers reloaded from INITIAL_*. Config pointer 0. FUVRF contents are not reset.
- Reset mid-frame discards partial sums; no output is produced for that frame.
- Latency is 2 cycles, valid_in to valid_out, fully pipelined, one vector per cycle.
  - Stage 1: register the input; read the FUVRF row at firmware_addr[chainId_in]; register that chain's firmware.
  - Stage 2: filter, reduce, accumulate; register the outputs.
- tracing=0: valid_out forced 0 each cycle. Inputs not captured. In-flight stage-1 data dropped. Accumulators held.
- Filter ops (firmware_op), producing F[m][n]:
  - 0 bypass: output = stage-1 vector. Reduce and accumulate are skipped.
  - 1 replicate: F[m][n] = v[n].
  - 2 threshold-value: F[m][n] = v[n] if signed v[n] >= thr[m], else 0.
  - 3 threshold-count: F[m][n] = 1 if signed v[n] >= thr[m], else 0.
  - Ops >= 4 behave as 0.
- Reduce (firmware_axis):
  - Axis 0 (along M): out[n] = sum over m of F[m][n].
  - Axis 1 (along N): out[m] = sum over n of F[m][n] for m < M; lanes m >= M are 0.
  - Sums are truncated modulo 2^DATA_WIDTH.
- Accumulate (firmware_accum bit0=1, op 1-3):
  - Each valid vector adds its reduced result into acc[chain], modulo 2^DATA_WIDTH.
  - Non-eof vector: no output.
  - eof vector: vector_out = acc + current result, valid_out=1, eof_out=1, then acc[chain] is cleared in the same cycle.
  - Accumulators of different chains are independent; interleaving chains is legal.
- Without accumulate: every valid vector produces an output; eof_out = delayed eof_in.
- Configuration (tracing=0 only):
  - Each cycle with configId==PERSONAL_CONFIG_ID, configData is written to firmware byte ptr, and ptr increments.
  - Byte order per chain c: op, addr, axis, accum, at index 4c+k.
  - ptr wraps to 0 after 4*MAX_CHAINS-1.
  - Any cycle with a non-matching configId resets ptr to 0.
  - Config bytes arriving with tracing=1 are ignored, and ptr is held.
  - Firmware addr values are used modulo FUVRF_SIZE.
- FUVRF:
  - Synchronous write on thr_we.
  - Same-cycle write and read of the same address returns the old row.
  - Initial contents are 0.

Test Plan:
- N=M=4, reset, op=1, axis=0, accum=0; drive v=[1,2,3,4] -> two cycles later vector_out=[4,8,12,16], valid_out=1; outputs are 0 during reset.
- op=3, axis=1, thr row=[0,2,3,10]; drive v=[1,2,3,4] -> vector_out=[4,3,2,0]. Same setup with op=2 -> [10,9,7,0].
- op=1, axis=0, accum=1 on chain 1; drive [1,1,1,1], then [2,2,2,2], then [1,0,0,0] with eof -> single output [16,12,12,12], eof_out=1. A following frame starts from 0. Chain 0 vectors interleaved in between do not disturb chain 1.
- Overflow: DATA_WIDTH=8, v=[0x7F,...], op=1, axis=0 -> lanes 0xFC (508 mod 256).
- Config: 16 matching bytes with tracing=0 load all chains; readback is observed via behaviour. A non-matching id mid-stream restarts at byte 0. Bytes sent with tracing=1 leave firmware unchanged.
- Deassert tracing mid-stream or assert rst_n=0 mid-frame -> valid_out=0 next cycle. After reset, the next eof emits only post-reset sums.

Source files
------------

// File: rtl/filter_reduce_accum_unit.sv
// ============================================================================
// Module  : filter_reduce_accum_unit
// Brief   : Per-chain filter (threshold rows) + axis reduce + frame accumulate.
// Revision: 1.0
// ============================================================================
`default_nettype none

module filter_reduce_accum_unit #(
    parameter int N                  = 8,
    parameter int M                  = 8,
    parameter int DATA_WIDTH         = 32,
    parameter int MAX_CHAINS         = 4,
    parameter int PERSONAL_CONFIG_ID = 0,
    parameter int FUVRF_SIZE         = 4,
    parameter logic [7:0] INITIAL_FIRMWARE_OP    [0:MAX_CHAINS-1] = '{default: 8'h00},
    parameter logic [7:0] INITIAL_FIRMWARE_ADDR  [0:MAX_CHAINS-1] = '{default: 8'h00},
    parameter logic [7:0] INITIAL_FIRMWARE_AXIS  [0:MAX_CHAINS-1] = '{default: 8'h00},
    parameter logic [7:0] INITIAL_FIRMWARE_ACCUM [0:MAX_CHAINS-1] = '{default: 8'h00}
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tracing,
    input  logic                          valid_in,
    input  logic                          eof_in,
    input  logic [$clog2(MAX_CHAINS)-1:0] chainId_in,
    input  logic [7:0]                    configId,
    input  logic [7:0]                    configData,
    input  logic                          thr_we,
    input  logic [$clog2(FUVRF_SIZE)-1:0] thr_addr,
    input  logic [M*DATA_WIDTH-1:0]       thr_data,
    input  logic [N*DATA_WIDTH-1:0]       vector_in,
    output logic [N*DATA_WIDTH-1:0]       vector_out,
    output logic [$clog2(MAX_CHAINS)-1:0] chainId_out,
    output logic                          valid_out,
    output logic                          eof_out
);

    localparam int c_CW    = $clog2(MAX_CHAINS);
    localparam int c_AW    = $clog2(FUVRF_SIZE);
    localparam int c_PTR_W = $clog2(4 * MAX_CHAINS);
    localparam logic [7:0]         c_CFG_ID  = 8'(PERSONAL_CONFIG_ID);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [DATA_WIDTH-1:0] c_ONE  = DATA_WIDTH'(1);

    // Firmware registers: only the bits that carry meaning are kept.
    logic [7:0]         r_fw_op    [0:MAX_CHAINS-1];
    logic [c_AW-1:0]    r_fw_addr  [0:MAX_CHAINS-1];
    logic               r_fw_axis  [0:MAX_CHAINS-1];
    logic               r_fw_accum [0:MAX_CHAINS-1];
    logic [c_PTR_W-1:0] r_cfg_ptr;
    logic [c_CW-1:0]    w_cfg_chain;

    logic [M*DATA_WIDTH-1:0] r_fuvrf [0:FUVRF_SIZE-1];

    // Stage-1 registers
    logic                    r1_valid;
    logic                    r1_eof;
    logic [c_CW-1:0]         r1_chain;
    logic [N*DATA_WIDTH-1:0] r1_vec;
    logic [M*DATA_WIDTH-1:0] r1_thr;
    logic [7:0]              r1_op;
    logic                    r1_axis;
    logic                    r1_accum;

    logic [N*DATA_WIDTH-1:0] r_acc [0:MAX_CHAINS-1];

    logic [DATA_WIDTH-1:0]   w_lane;
    logic [DATA_WIDTH-1:0]   w_thr;
    logic [DATA_WIDTH-1:0]   w_filt [0:M-1][0:N-1];
    logic [DATA_WIDTH-1:0]   w_red  [0:N-1];
    logic [N*DATA_WIDTH-1:0] w_red_flat;
    logic [N*DATA_WIDTH-1:0] w_acc_sum;
    logic                    w_bypass;

    assign w_cfg_chain = r_cfg_ptr[c_PTR_W-1:2];

    // Config bytes land only while the pipeline is idle; any foreign id rewinds the pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cfg_ptr <= '0;
            for (int c = 0; c < MAX_CHAINS; c++) begin
                r_fw_op[c]    <= INITIAL_FIRMWARE_OP[c];
                r_fw_addr[c]  <= INITIAL_FIRMWARE_ADDR[c][c_AW-1:0];
                r_fw_axis[c]  <= INITIAL_FIRMWARE_AXIS[c][0];
                r_fw_accum[c] <= INITIAL_FIRMWARE_ACCUM[c][0];
            end
        end else if (!tracing) begin
            if (configId == c_CFG_ID) begin
                case (r_cfg_ptr[1:0])
                    2'd0:    r_fw_op[w_cfg_chain]    <= configData;
                    2'd1:    r_fw_addr[w_cfg_chain]  <= configData[c_AW-1:0];
                    2'd2:    r_fw_axis[w_cfg_chain]  <= configData[0];
                    default: r_fw_accum[w_cfg_chain] <= configData[0];
                endcase
                r_cfg_ptr <= r_cfg_ptr + c_PTR_ONE;
            end else begin
                r_cfg_ptr <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (thr_we) begin
            r_fuvrf[thr_addr] <= thr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r1_valid <= 1'b0;
        end else begin
            r1_valid <= tracing & valid_in;
        end
    end

    always_ff @(posedge clk) begin
        if (tracing && valid_in) begin
            r1_eof   <= eof_in;
            r1_chain <= chainId_in;
            r1_vec   <= vector_in;
            r1_thr   <= r_fuvrf[r_fw_addr[chainId_in]];
            r1_op    <= r_fw_op[chainId_in];
            r1_axis  <= r_fw_axis[chainId_in];
            r1_accum <= r_fw_accum[chainId_in];
        end
    end

    assign w_bypass = !(r1_op inside {8'd1, 8'd2, 8'd3});

    always_comb begin
        w_lane = '0;
        w_thr  = '0;
        for (int m = 0; m < M; m++) begin
            for (int n = 0; n < N; n++) begin
                w_lane = r1_vec[n*DATA_WIDTH +: DATA_WIDTH];
                w_thr  = r1_thr[m*DATA_WIDTH +: DATA_WIDTH];
                case (r1_op)
                    8'd1:    w_filt[m][n] = w_lane;
                    8'd2:    w_filt[m][n] = ($signed(w_lane) >= $signed(w_thr)) ? w_lane : '0;
                    8'd3:    w_filt[m][n] = ($signed(w_lane) >= $signed(w_thr)) ? c_ONE : '0;
                    default: w_filt[m][n] = '0;
                endcase
            end
        end
    end

    // Axis 1 leaves lanes M..N-1 at zero.
    always_comb begin
        for (int n = 0; n < N; n++) begin
            w_red[n] = '0;
        end
        if (!r1_axis) begin
            for (int n = 0; n < N; n++) begin
                for (int m = 0; m < M; m++) begin
                    w_red[n] = w_red[n] + w_filt[m][n];
                end
            end
        end else begin
            for (int m = 0; m < M && m < N; m++) begin
                for (int n = 0; n < N; n++) begin
                    w_red[m] = w_red[m] + w_filt[m][n];
                end
            end
        end
    end

    always_comb begin
        w_red_flat = '0;
        w_acc_sum  = '0;
        for (int n = 0; n < N; n++) begin
            w_red_flat[n*DATA_WIDTH +: DATA_WIDTH] = w_red[n];
            w_acc_sum[n*DATA_WIDTH +: DATA_WIDTH]  =
                r_acc[r1_chain][n*DATA_WIDTH +: DATA_WIDTH] + w_red[n];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vector_out  <= '0;
            chainId_out <= '0;
            valid_out   <= 1'b0;
            eof_out     <= 1'b0;
            for (int c = 0; c < MAX_CHAINS; c++) begin
                r_acc[c] <= '0;
            end
        end else if (tracing && r1_valid) begin
            chainId_out <= r1_chain;
            if (w_bypass) begin
                vector_out <= r1_vec;
                valid_out  <= 1'b1;
                eof_out    <= r1_eof;
            end else if (r1_accum) begin
                if (r1_eof) begin
                    vector_out      <= w_acc_sum;
                    valid_out       <= 1'b1;
                    eof_out         <= 1'b1;
                    r_acc[r1_chain] <= '0;
                end else begin
                    r_acc[r1_chain] <= w_acc_sum;
                    valid_out       <= 1'b0;
                    eof_out         <= 1'b0;
                end
            end else begin
                vector_out <= w_red_flat;
                valid_out  <= 1'b1;
                eof_out    <= r1_eof;
            end
        end else begin
            valid_out <= 1'b0;
            eof_out   <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_filter_reduce_accum_unit.sv
// ============================================================================
// Module  : tb_filter_reduce_accum_unit
// Brief   : Directed scenarios plus randomized stream against a lane-level model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_filter_reduce_accum_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tracing;
    logic        valid_in;
    logic        eof_in;
    logic [1:0]  chainId_in;
    logic [7:0]  configId;
    logic [7:0]  configData;
    logic        thr_we;
    logic [1:0]  thr_addr;
    logic [31:0] thr_data;
    logic [31:0] vector_in;
    logic [31:0] vector_out;
    logic [1:0]  chainId_out;
    logic        valid_out;
    logic        eof_out;

    int checks = 0;
    int errors = 0;

    logic [7:0]  cfg_buf [0:19];
    logic [31:0] mdl_thr [0:3];
    logic [31:0] mdl_acc [0:3];

    filter_reduce_accum_unit #(
        .N(4), .M(4), .DATA_WIDTH(8), .MAX_CHAINS(4),
        .PERSONAL_CONFIG_ID(0), .FUVRF_SIZE(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tracing(tracing), .valid_in(valid_in),
        .eof_in(eof_in), .chainId_in(chainId_in), .configId(configId),
        .configData(configData), .thr_we(thr_we), .thr_addr(thr_addr),
        .thr_data(thr_data), .vector_in(vector_in), .vector_out(vector_out),
        .chainId_out(chainId_out), .valid_out(valid_out), .eof_out(eof_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    // Builds the M x N matrix from the rules and sums along the chosen axis.
    function automatic logic [31:0] reduce_model(input logic [7:0] op, input logic axis,
                                                 input logic [31:0] thr, input logic [31:0] v);
        int f [4][4];
        int s;
        logic signed [7:0] vn, tm;
        logic [31:0] r;
        r = '0;
        if (op == 8'd0 || op > 8'd3) return v;
        for (int m = 0; m < 4; m++) begin
            for (int n = 0; n < 4; n++) begin
                vn = v[n*8 +: 8];
                tm = thr[m*8 +: 8];
                if (op == 8'd1)   f[m][n] = int'(v[n*8 +: 8]);
                else if (vn >= tm) f[m][n] = (op == 8'd2) ? int'(v[n*8 +: 8]) : 1;
                else               f[m][n] = 0;
            end
        end
        for (int k = 0; k < 4; k++) begin
            s = 0;
            for (int j = 0; j < 4; j++) s += axis ? f[k][j] : f[j][k];
            r[k*8 +: 8] = s[7:0];
        end
        return r;
    endfunction

    function automatic logic [31:0] add4(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s;
        for (int n = 0; n < 4; n++) s[n*8 +: 8] = a[n*8 +: 8] + b[n*8 +: 8];
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [1:0] c, input logic [31:0] d);
        valid_in   = 1'b1;
        eof_in     = e;
        chainId_in = c;
        vector_in  = d;
    endtask

    task automatic idle();
        valid_in = 1'b0;
        eof_in   = 1'b0;
    endtask

    task automatic cfg_send(input int nbytes);
        idle();
        tracing  = 1'b0;
        configId = 8'hFF;
        tick();
        for (int i = 0; i < nbytes; i++) begin
            configId   = 8'h00;
            configData = cfg_buf[i];
            tick();
        end
        configId = 8'hFF;
        tick();
        tracing = 1'b1;
    endtask

    task automatic cfg_uniform(input int op, input int addr, input int axis, input int acc);
        for (int c = 0; c < 4; c++) begin
            cfg_buf[4*c]   = op[7:0];
            cfg_buf[4*c+1] = addr[7:0];
            cfg_buf[4*c+2] = axis[7:0];
            cfg_buf[4*c+3] = acc[7:0];
        end
        cfg_send(16);
    endtask

    task automatic write_thr(input logic [1:0] a, input logic [31:0] row);
        thr_we   = 1'b1;
        thr_addr = a;
        thr_data = row;
        tick();
        thr_we   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        tracing = 1'b1;
        drive(1'b1, 2'd3, pack4(9, 9, 9, 9));
        tick();
        tick();
        if (vector_out !== 32'h0 || valid_out !== 1'b0 || eof_out !== 1'b0 || chainId_out !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: vec=%h valid=%0b eof=%0b chain=%0d, expected all zero",
                     vector_out, valid_out, eof_out, chainId_out);
        end
        checks++;
        idle();
        rst_n = 1'b1;
        tick();
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_output: valid=%0b expected 0", valid_out);
        end
        checks++;
    endtask

    task automatic test_bypass_after_reset();
        drive(1'b1, 2'd3, pack4(9, 8, 7, 6));
        tick();
        idle();
        tick();
        if (valid_out !== 1'b1 || vector_out !== pack4(9, 8, 7, 6) || eof_out !== 1'b1 || chainId_out !== 2'd3) begin
            errors++;
            $display("FAIL bypass: valid=%0b vec=%h eof=%0b chain=%0d, expected valid=1 vec=%h eof=1 chain=3",
                     valid_out, vector_out, eof_out, chainId_out, pack4(9, 8, 7, 6));
        end
        checks++;
    endtask

    task automatic test_replicate();
        cfg_uniform(1, 0, 0, 0);
        drive(1'b0, 2'd2, pack4(1, 2, 3, 4));
        tick();
        idle();
        tick();
        if (valid_out !== 1'b1 || vector_out !== pack4(4, 8, 12, 16) || eof_out !== 1'b0 || chainId_out !== 2'd2) begin
            errors++;
            $display("FAIL replicate: valid=%0b vec=%h eof=%0b chain=%0d, expected valid=1 vec=%h eof=0 chain=2",
                     valid_out, vector_out, eof_out, chainId_out, pack4(4, 8, 12, 16));
        end
        checks++;
        tick();
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL replicate_single: valid=%0b expected 0", valid_out);
        end
        checks++;
    endtask

    task automatic test_threshold();
        write_thr(2'd1, pack4(0, 2, 3, 10));
        cfg_uniform(3, 1, 1, 0);
        drive(1'b0, 2'd0, pack4(1, 2, 3, 4));
        tick();
        idle();
        tick();
        if (valid_out !== 1'b1 || vector_out !== pack4(4, 3, 2, 0)) begin
            errors++;
            $display("FAIL thr_count: valid=%0b vec=%h, expected valid=1 vec=%h", valid_out, vector_out, pack4(4, 3, 2, 0));
        end
        checks++;
        cfg_uniform(2, 1, 1, 0);
        drive(1'b0, 2'd0, pack4(1, 2, 3, 4));
        tick();
        idle();
        tick();
        if (valid_out !== 1'b1 || vector_out !== pack4(10, 9, 7, 0)) begin
            errors++;
            $display("FAIL thr_value: valid=%0b vec=%h, expected valid=1 vec=%h", valid_out, vector_out, pack4(10, 9, 7, 0));
        end
        checks++;
    endtask

    task automatic test_overflow_back_to_back();
        cfg_uniform(1, 0, 0, 0);
        drive(1'b0, 2'd0, pack4(127, 127, 127, 127));
        tick();
        drive(1'b1, 2'd1, pack4(128, 128, 64, 1));
        tick();
        if (valid_out !== 1'b1 || vector_out !== pack4(252, 252, 252, 252)) begin
            errors++;
            $display("FAIL overflow: valid=%0b vec=%h, expected valid=1 vec=%h", valid_out, vector_out, pack4(252, 252, 252, 252));
        end
        checks++;
        idle();
        tick();
        if (valid_out !== 1'b1 || vector_out !== pack4(0, 0, 0, 4) || eof_out !== 1'b1 || chainId_out !== 2'd1) begin
            errors++;
            $display("FAIL back_to_back: valid=%0b vec=%h eof=%0b chain=%0d, expected valid=1 vec=%h eof=1 chain=1",
                     valid_out, vector_out, eof_out, chainId_out, pack4(0, 0, 0, 4));
        end
        checks++;
    endtask

    task automatic test_config();
        cfg_uniform(1, 0, 0, 0);
        // Two bytes, a foreign id, then a fresh chain-0 record.
        tracing  = 1'b0;
        configId = 8'hFF;
        tick();
        configId = 8'h00; configData = 8'd0; tick();
        configData = 8'd0; tick();
        configId = 8'h05; tick();
        configId = 8'h00;
        configData = 8'd1; tick();
        configData = 8'd0; tick();
        configData = 8'd1; tick();
        configData = 8'd0; tick();
        configId = 8'hFF;
        tick();
        tracing = 1'b1;
        drive(1'b0, 2'd0, pack4(1, 2, 3, 4));
        tick();
        idle();
        tick();
        if (valid_out !== 1'b1 || vector_out !== pack4(10, 10, 10, 10)) begin
            errors++;
            $display("FAIL cfg_restart: valid=%0b vec=%h, expected valid=1 vec=%h", valid_out, vector_out, pack4(10, 10, 10, 10));
        end
        checks++;
        configId   = 8'h00;
        configData = 8'h00;
        repeat (4) tick();
        configId = 8'hFF;
        drive(1'b0, 2'd0, pack4(1, 2, 3, 4));
        tick();
        idle();
        tick();
        if (valid_out !== 1'b1 || vector_out !== pack4(10, 10, 10, 10)) begin
            errors++;
            $display("FAIL cfg_tracing_ignored: valid=%0b vec=%h, expected valid=1 vec=%h", valid_out, vector_out, pack4(10, 10, 10, 10));
        end
        checks++;
        for (int c = 0; c < 4; c++) begin
            cfg_buf[4*c] = 8'd1; cfg_buf[4*c+1] = 8'd0; cfg_buf[4*c+2] = 8'd0; cfg_buf[4*c+3] = 8'd0;
        end
        cfg_buf[16] = 8'd2; cfg_buf[17] = 8'd1; cfg_buf[18] = 8'd0; cfg_buf[19] = 8'd0;
        cfg_send(20);
        drive(1'b0, 2'd0, pack4(1, 2, 3, 4));
        tick();
        drive(1'b0, 2'd1, pack4(1, 2, 3, 4));
        tick();
        if (valid_out !== 1'b1 || vector_out !== pack4(1, 4, 9, 12)) begin
            errors++;
            $display("FAIL cfg_wrap: valid=%0b vec=%h, expected valid=1 vec=%h", valid_out, vector_out, pack4(1, 4, 9, 12));
        end
        checks++;
        idle();
        tick();
        if (valid_out !== 1'b1 || vector_out !== pack4(4, 8, 12, 16)) begin
            errors++;
            $display("FAIL cfg_wrap_other_chain: valid=%0b vec=%h, expected valid=1 vec=%h", valid_out, vector_out, pack4(4, 8, 12, 16));
        end
        checks++;
    endtask

    task automatic test_accum();
        for (int c = 0; c < 4; c++) begin
            cfg_buf[4*c] = 8'd1; cfg_buf[4*c+1] = 8'd0; cfg_buf[4*c+2] = 8'd0;
            cfg_buf[4*c+3] = (c == 1) ? 8'd1 : 8'd0;
        end
        cfg_send(16);
        drive(1'b0, 2'd1, pack4(1, 1, 1, 1));
        tick();
        drive(1'b0, 2'd0, pack4(5, 6, 7, 8));
        tick();
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL accum_silent: valid=%0b expected 0", valid_out);
        end
        checks++;
        drive(1'b0, 2'd1, pack4(2, 2, 2, 2));
        tick();
        if (valid_out !== 1'b1 || vector_out !== pack4(20, 24, 28, 32) || chainId_out !== 2'd0 || eof_out !== 1'b0) begin
            errors++;
            $display("FAIL accum_interleave: valid=%0b vec=%h chain=%0d eof=%0b, expected valid=1 vec=%h chain=0 eof=0",
                     valid_out, vector_out, chainId_out, eof_out, pack4(20, 24, 28, 32));
        end
        checks++;
        drive(1'b1, 2'd1, pack4(1, 0, 0, 0));
        tick();
        idle();
        tick();
        if (valid_out !== 1'b1 || vector_out !== pack4(16, 12, 12, 12) || chainId_out !== 2'd1 || eof_out !== 1'b1) begin
            errors++;
            $display("FAIL accum_eof: valid=%0b vec=%h chain=%0d eof=%0b, expected valid=1 vec=%h chain=1 eof=1",
                     valid_out, vector_out, chainId_out, eof_out, pack4(16, 12, 12, 12));
        end
        checks++;
        drive(1'b1, 2'd1, pack4(1, 1, 1, 1));
        tick();
        idle();
        tick();
        if (valid_out !== 1'b1 || vector_out !== pack4(4, 4, 4, 4) || eof_out !== 1'b1) begin
            errors++;
            $display("FAIL accum_cleared: valid=%0b vec=%h eof=%0b, expected valid=1 vec=%h eof=1",
                     valid_out, vector_out, eof_out, pack4(4, 4, 4, 4));
        end
        checks++;
    endtask

    task automatic test_tracing();
        drive(1'b0, 2'd0, pack4(1, 1, 1, 1));
        tick();
        tracing = 1'b0;
        drive(1'b0, 2'd0, pack4(2, 2, 2, 2));
        tick();
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL tracing_drop: valid=%0b expected 0", valid_out);
        end
        checks++;
        tick();
        tracing = 1'b1;
        idle();
        tick();
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL tracing_no_capture: valid=%0b expected 0", valid_out);
        end
        checks++;
        drive(1'b0, 2'd1, pack4(1, 1, 1, 1));
        tick();
        idle();
        tick();
        tracing = 1'b0;
        repeat (3) tick();
        tracing = 1'b1;
        drive(1'b1, 2'd1, pack4(1, 0, 0, 0));
        tick();
        idle();
        tick();
        if (valid_out !== 1'b1 || vector_out !== pack4(8, 4, 4, 4) || eof_out !== 1'b1) begin
            errors++;
            $display("FAIL tracing_acc_held: valid=%0b vec=%h eof=%0b, expected valid=1 vec=%h eof=1",
                     valid_out, vector_out, eof_out, pack4(8, 4, 4, 4));
        end
        checks++;
    endtask

    task automatic test_reset_midframe();
        drive(1'b0, 2'd1, pack4(1, 1, 1, 1));
        tick();
        drive(1'b0, 2'd1, pack4(3, 3, 3, 3));
        tick();
        rst_n = 1'b0;
        idle();
        tick();
        if (valid_out !== 1'b0 || vector_out !== 32'h0 || eof_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_midframe: valid=%0b vec=%h eof=%0b, expected all zero", valid_out, vector_out, eof_out);
        end
        checks++;
        rst_n = 1'b1;
        cfg_send(16);
        drive(1'b1, 2'd1, pack4(2, 2, 2, 2));
        tick();
        idle();
        tick();
        if (valid_out !== 1'b1 || vector_out !== pack4(8, 8, 8, 8) || eof_out !== 1'b1 || chainId_out !== 2'd1) begin
            errors++;
            $display("FAIL reset_post_sum: valid=%0b vec=%h eof=%0b chain=%0d, expected valid=1 vec=%h eof=1 chain=1",
                     valid_out, vector_out, eof_out, chainId_out, pack4(8, 8, 8, 8));
        end
        checks++;
    endtask

    task automatic test_random();
        logic        cur_v, cur_e, prev_v, prev_e;
        logic [1:0]  cur_c, prev_c, c;
        logic [31:0] cur_d, prev_d, d, red;
        logic        e;
        logic [7:0]  op;
        logic        ax, ac;
        int          K;
        K = 300;
        rst_n = 1'b0;
        idle();
        tick();
        rst_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            mdl_thr[a] = $urandom;
            write_thr(a[1:0], mdl_thr[a]);
        end
        for (int k = 0; k < 4; k++) begin
            cfg_buf[4*k]   = 8'($urandom_range(0, 5));
            cfg_buf[4*k+1] = 8'($urandom_range(0, 255));
            cfg_buf[4*k+2] = 8'($urandom_range(0, 1));
            cfg_buf[4*k+3] = 8'($urandom_range(0, 1));
            mdl_acc[k]     = '0;
        end
        cfg_send(16);
        prev_v = 1'b0; prev_e = 1'b0; prev_c = '0; prev_d = '0;
        for (int i = 0; i <= K; i++) begin
            cur_v = 1'b0; cur_e = 1'b0; cur_c = '0; cur_d = '0;
            if (i < K && $urandom_range(0, 3) != 0) begin
                c  = 2'($urandom_range(0, 3));
                e  = ($urandom_range(0, 3) == 0);
                d  = $urandom;
                op = cfg_buf[4*c];
                ax = cfg_buf[4*c+2][0];
                ac = cfg_buf[4*c+3][0];
                drive(e, c, d);
                red = reduce_model(op, ax, mdl_thr[cfg_buf[4*c+1][1:0]], d);
                cur_c = c;
                if (op == 8'd0 || op > 8'd3) begin
                    cur_v = 1'b1; cur_e = e; cur_d = d;
                end else if (ac) begin
                    if (e) begin
                        cur_v = 1'b1; cur_e = 1'b1; cur_d = add4(mdl_acc[c], red);
                        mdl_acc[c] = '0;
                    end else begin
                        mdl_acc[c] = add4(mdl_acc[c], red);
                    end
                end else begin
                    cur_v = 1'b1; cur_e = e; cur_d = red;
                end
            end else begin
                idle();
            end
            tick();
            if (i > 0) begin
                if (valid_out !== prev_v ||
                    (prev_v && (vector_out !== prev_d || eof_out !== prev_e || chainId_out !== prev_c))) begin
                    errors++;
                    $display("FAIL random[%0d]: valid=%0b vec=%h eof=%0b chain=%0d, expected valid=%0b vec=%h eof=%0b chain=%0d",
                             i - 1, valid_out, vector_out, eof_out, chainId_out, prev_v, prev_d, prev_e, prev_c);
                end
                checks++;
            end
            prev_v = cur_v; prev_e = cur_e; prev_c = cur_c; prev_d = cur_d;
        end
        idle();
    endtask

    initial begin
        rst_n      = 1'b0;
        tracing    = 1'b0;
        valid_in   = 1'b0;
        eof_in     = 1'b0;
        chainId_in = '0;
        configId   = 8'hFF;
        configData = '0;
        thr_we     = 1'b0;
        thr_addr   = '0;
        thr_data   = '0;
        vector_in  = '0;
        test_reset();
        test_bypass_after_reset();
        test_replicate();
        test_threshold();
        test_overflow_back_to_back();
        test_config();
        test_accum();
        test_tracing();
        test_reset_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
